// File: rtl/irrig_pkg.sv
// Shared state encoding and default timing constants for the irrigation sequencer.
package irrig_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        GOTEJ  = 3'd1,
        ASPERS = 3'd2,
        PAUSA  = 3'd3,
        FALHA  = 3'd4
    } state_t;

    localparam int unsigned MIN_ON_DEF    = 8;
    localparam int unsigned DEAD_DEF      = 4;
    localparam int unsigned BLINK_DIV_DEF = 16;
    localparam int unsigned MAX_ON_DEF    = 1024;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarme_pisca.sv
// Buzzer driver: steady on sensor error, square wave of half-period BLINK_DIV on alarm.
module alarme_pisca
    import irrig_pkg::*;
#(
    parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic erro_i,
    input  logic al_i,
    output logic buz_o
);

    localparam int unsigned CW = $clog2(BLINK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          buz_q, buz_d;

    // Phase 0 shows the buzzer on, so the first alarm cycle is audible at once.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        buz_d   = 1'b0;
        if (erro_i) begin
            buz_d = 1'b1;
        end else if (al_i) begin
            buz_d = ~phase_q;
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            buz_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            buz_q   <= buz_d;
        end
    end

    assign buz_o = buz_q;

endmodule

// File: rtl/irrig_sequenciador.sv
// Irrigation actuator sequencer: minimum on-time, dead-time, fault lockout and alarm buzzer.
// Defining IRRIG_MAX_ON_EN adds a continuous-irrigation limit with same-mode re-entry hold-off.
module irrig_sequenciador
    import irrig_pkg::*;
#(
    parameter int unsigned MIN_ON    = MIN_ON_DEF,
    parameter int unsigned DEAD      = DEAD_DEF,
    parameter int unsigned BLINK_DIV = BLINK_DIV_DEF,
    parameter int unsigned MAX_ON    = MAX_ON_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Vs,
    input  logic               Bs,
    input  logic               Ve,
    input  logic               Al,
    input  logic               Erro,
    input  logic               Vazio,
    output logic               Vg,
    output logic               Va,
    output logic               Vi,
    output logic               Buz,
    output logic [STATE_W-1:0] estado
);

    localparam int unsigned TW = $clog2(max_u(max_u(MIN_ON, DEAD), MAX_ON) + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          vg_q, va_q, vi_q;
    logic          flt, in_irrig, min_met;
    logic          vs_ok, bs_ok, run_lim;

    assign flt      = Erro | Vazio;
    assign in_irrig = (state_q == GOTEJ) || (state_q == ASPERS);
    // timer holds the cycles already spent in the state, so this cycle completes MIN_ON.
    assign min_met  = (timer_q >= TW'(MIN_ON - 1));

`ifdef IRRIG_MAX_ON_EN
    localparam int unsigned HOLD = DEAD + MAX_ON / 4;
    localparam int unsigned RW   = $clog2(MAX_ON + 1);
    localparam int unsigned HW   = $clog2(HOLD + 1);

    logic [RW-1:0] run_q, run_d;
    logic [HW-1:0] hold_q, hold_d;
    state_t        hold_mode_q, hold_mode_d;

    assign run_lim = (run_q == RW'(MAX_ON - 1));
    assign vs_ok   = Vs & ~((hold_q != '0) & (hold_mode_q == GOTEJ));
    assign bs_ok   = Bs & ~((hold_q != '0) & (hold_mode_q == ASPERS));

    always_comb begin
        run_d       = '0;
        hold_d      = (hold_q != '0) ? hold_q - HW'(1) : '0;
        hold_mode_d = hold_mode_q;
        if (in_irrig && (state_d == state_q) && !run_lim) begin
            run_d = run_q + RW'(1);
        end
        // A forced exit blocks only the mode that hit the limit.
        if (in_irrig && (state_d == PAUSA) && run_lim) begin
            hold_d      = HW'(HOLD);
            hold_mode_d = state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q       <= '0;
            hold_q      <= '0;
            hold_mode_q <= IDLE;
        end else begin
            run_q       <= run_d;
            hold_q      <= hold_d;
            hold_mode_q <= hold_mode_d;
        end
    end
`else
    assign run_lim = 1'b0;
    assign vs_ok   = Vs;
    assign bs_ok   = Bs;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flt) begin
                    state_d = FALHA;
                end else if (vs_ok) begin
                    state_d = GOTEJ;
                end else if (bs_ok) begin
                    state_d = ASPERS;
                end
            end
            GOTEJ: begin
                if (flt) begin
                    state_d = FALHA;
                end else if (run_lim || (!Vs && min_met)) begin
                    state_d = PAUSA;
                end
            end
            ASPERS: begin
                if (flt) begin
                    state_d = FALHA;
                end else if (run_lim || (!Bs && min_met)) begin
                    state_d = PAUSA;
                end
            end
            PAUSA: begin
                if (flt) begin
                    state_d = FALHA;
                end else if (timer_q == TW'(DEAD - 1)) begin
                    state_d = IDLE;
                end
            end
            FALHA: begin
                if (!flt) begin
                    state_d = PAUSA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (state_d == state_q) begin
            if (in_irrig) begin
                timer_d = (timer_q == TW'(MIN_ON)) ? timer_q : timer_q + TW'(1);
            end else if (state_q == PAUSA) begin
                timer_d = (timer_q == TW'(DEAD)) ? timer_q : timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            vg_q    <= 1'b0;
            va_q    <= 1'b0;
            vi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            vg_q    <= (state_d == GOTEJ);
            va_q    <= (state_d == ASPERS);
            vi_q    <= Ve & ~Erro;
        end
    end

    alarme_pisca #(
        .BLINK_DIV (BLINK_DIV)
    ) u_alarme_pisca (
        .clk    (clk),
        .rst    (rst),
        .erro_i (Erro),
        .al_i   (Al),
        .buz_o  (Buz)
    );

    assign Vg     = vg_q;
    assign Va     = va_q;
    assign Vi     = vi_q;
    assign estado = state_q;

endmodule

// File: tb/tb_irrig_sequenciador.sv
// Scoreboard bench for irrig_sequenciador with MIN_ON=4, DEAD=2, BLINK_DIV=3.
module tb_irrig_sequenciador;

    logic       clk = 1'b0;
    logic       rst, Vs, Bs, Ve, Al, Erro, Vazio;
    logic       Vg, Va, Vi, Buz;
    logic [2:0] estado;

    int errors = 0;
    int checks = 0;

    string      nm_q[$];
    logic [6:0] exp_q[$];

    irrig_sequenciador #(
        .MIN_ON    (4),
        .DEAD      (2),
        .BLINK_DIV (3),
        .MAX_ON    (10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Vs     (Vs),
        .Bs     (Bs),
        .Ve     (Ve),
        .Al     (Al),
        .Erro   (Erro),
        .Vazio  (Vazio),
        .Vg     (Vg),
        .Va     (Va),
        .Vi     (Vi),
        .Buz    (Buz),
        .estado (estado)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic drv(input string nm,
                       input logic r, input logic vs, input logic bs, input logic ve,
                       input logic al, input logic er, input logic vz,
                       input logic vg, input logic va, input logic vi, input logic bz,
                       input logic [2:0] est);
        @(negedge clk);
        rst = r; Vs = vs; Bs = bs; Ve = ve; Al = al; Erro = er; Vazio = vz;
        nm_q.push_back(nm);
        exp_q.push_back({vg, va, vi, bz, est});
    endtask

    initial begin : monitor
        string      n;
        logic [6:0] e;
        logic [6:0] got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                n   = nm_q.pop_front();
                got = {Vg, Va, Vi, Buz, estado};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got Vg Va Vi Buz estado=%b expected %b", n, got, e);
                end
                checks++;
                if ((Vg & Va) === 1'b1) begin
                    errors++;
                    $display("FAIL interlock %s: Vg=%b Va=%b expected not both 1", n, Vg, Va);
                end
            end
        end
    end

    initial begin : stimulus
        logic [11:0] pat;
        pat = 12'b111000111000;
        rst = 1'b1; Vs = 1'b1; Bs = 1'b0; Ve = 1'b0; Al = 1'b0; Erro = 1'b0; Vazio = 1'b0;

        // reset with Vs held, then release
        drv("rst_hold",    1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);
        drv("rst_hold",    1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);
        drv("rst_release", 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        repeat (3) drv("rst_gotej", 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        drv("rst_exit",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("rst_pausa",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("rst_idle",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        // one-cycle Vs pulse: 1,1,1,1,3,3,0
        drv("minon_pulse", 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        repeat (3) drv("minon_hold", 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        drv("minon_pausa", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("minon_pausa", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("minon_idle",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        // Vs and Bs together: drip first, sprinkler only after PAUSA and IDLE
        drv("mutex_enter", 0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        repeat (5) drv("mutex_hold", 0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        drv("mutex_drop",  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("mutex_pausa", 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("mutex_idle",  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);
        drv("mutex_asp",   0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 3'd2);
        repeat (3) drv("asp_hold", 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 3'd2);
        drv("asp_exit",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("asp_pausa",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("asp_idle",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        // Erro during drip overrides MIN_ON and blocks the inlet
        drv("flt_enter",   0, 1, 0, 1, 0, 0, 0,  1, 0, 1, 0, 3'd1);
        drv("flt_gotej",   0, 1, 0, 1, 0, 0, 0,  1, 0, 1, 0, 3'd1);
        drv("flt_erro",    0, 1, 0, 1, 0, 1, 0,  0, 0, 0, 1, 3'd4);
        drv("flt_hold",    0, 1, 0, 1, 0, 1, 0,  0, 0, 0, 1, 3'd4);
        drv("flt_clear",   0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 3'd3);
        drv("flt_pausa",   0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 3'd3);
        drv("flt_idle",    0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 3'd0);

        // Vazio faults from IDLE but keeps the inlet open
        drv("vazio_enter", 0, 1, 0, 1, 0, 0, 1,  0, 0, 1, 0, 3'd4);
        drv("vazio_clear", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("vazio_pausa", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd3);
        drv("vazio_idle",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        // alarm blink 111000111000, then off
        for (int i = 0; i < 12; i++) begin
            drv("blink", 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, pat[11-i], 3'd0);
        end
        drv("blink_off",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        // Erro wins over Al and restarts the blink phase
        drv("buz_erro",    0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 3'd4);
        drv("buz_restart", 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 3'd3);
        drv("buz_restart", 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 3'd3);
        drv("buz_off",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        // reset mid-irrigation closes the valve on the next edge
        drv("mid_enter",   0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd1);
        drv("mid_rst",     1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);
        drv("mid_idle",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
